// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and small op-decode helpers also used by the main control unit.
package mdu_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  function automatic logic isSignedOp(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic isDivOp(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation. Used both to take operand
// magnitudes on accept and to restore result signs in FIX.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val_i,
  input  logic         neg_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative radix-2 multiply / restoring divide unit producing HI/LO.
// One iteration per cycle over WIDTH cycles, then a single FIX cycle that
// restores signs and writes HI/LO.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  input  logic             start,
  input  logic             hi_we,
  input  logic             lo_we,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mdu_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [1:0]         op_q, op_d;
  logic               signA_q, signA_d;
  logic               signB_q, signB_d;
  logic               divZero_q, divZero_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;

  logic [WIDTH-1:0]   absA, absB;
  logic [2*WIDTH-1:0] prodFixed;
  logic [WIDTH-1:0]   quotFixed, remFixed;
  logic [WIDTH:0]     addSum, trialRem, trialDiff;
  logic [2*WIDTH-1:0] mulStep, divStep;
  logic               resNeg;

  assign resNeg = signA_q ^ signB_q;

  mdu_sign_fix #(.W(WIDTH)) u_absA (
    .val_i(A), .neg_i(isSignedOp(op) & A[WIDTH-1]), .val_o(absA));
  mdu_sign_fix #(.W(WIDTH)) u_absB (
    .val_i(B), .neg_i(isSignedOp(op) & B[WIDTH-1]), .val_o(absB));
  mdu_sign_fix #(.W(2*WIDTH)) u_fixProd (
    .val_i(acc_q), .neg_i(resNeg), .val_o(prodFixed));
  mdu_sign_fix #(.W(WIDTH)) u_fixQuot (
    .val_i(acc_q[WIDTH-1:0]), .neg_i(resNeg), .val_o(quotFixed));
  mdu_sign_fix #(.W(WIDTH)) u_fixRem (
    .val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(signA_q), .val_o(remFixed));

  // Multiply: acc holds {partial product, remaining multiplier bits}; add the
  // multiplicand into the top half when the multiplier LSB is set, then shift
  // right keeping the carry.
  assign addSum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
  assign mulStep = acc_q[0] ? {addSum, acc_q[WIDTH-1:1]}
                            : {1'b0, acc_q[2*WIDTH-1:1]};

  // Divide: acc holds {partial remainder, remaining dividend bits}; trial
  // subtract the divisor from the shifted remainder and shift in the quotient
  // bit. A zero divisor always "succeeds", so the remainder ends up as the
  // dividend magnitude and the quotient as all ones.
  assign trialRem  = acc_q[2*WIDTH-1:WIDTH-1];
  assign trialDiff = trialRem - {1'b0, opnd_q};
  assign divStep   = trialDiff[WIDTH] ? {acc_q[2*WIDTH-2:0], 1'b0}
                                      : {trialDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Next-state logic: accept/MTHI/MTLO in idle, iterate in CALC, write HI/LO in FIX.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    signA_d   = signA_q;
    signB_d   = signB_q;
    divZero_d = divZero_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CALC;
          cnt_d     = '0;
          op_d      = op;
          signA_d   = isSignedOp(op) & A[WIDTH-1];
          signB_d   = isSignedOp(op) & B[WIDTH-1];
          divZero_d = (B == '0);
          if (isDivOp(op)) begin
            acc_d  = {{WIDTH{1'b0}}, absA};
            opnd_d = absB;
          end else begin
            acc_d  = {{WIDTH{1'b0}}, absB};
            opnd_d = absA;
          end
        end else begin
          if (hi_we) hi_d = A;
          if (lo_we) lo_d = A;
        end
      end
      S_CALC: begin
        acc_d = isDivOp(op_q) ? divStep : mulStep;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (isDivOp(op_q)) begin
          hi_d = remFixed;
          lo_d = divZero_q ? '1 : quotFixed;
        end else begin
          hi_d = prodFixed[2*WIDTH-1:WIDTH];
          lo_d = prodFixed[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any in-flight operation and clears HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      op_q      <= OP_MULT;
      signA_q   <= 1'b0;
      signB_q   <= 1'b0;
      divZero_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      signA_q   <= signA_d;
      signB_q   <= signB_d;
      divZero_q <= divZero_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard testbench for mult_div_unit: directed cases plus randomized ops
// checked against an arithmetic reference model.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] A, B;
  logic [1:0]   op;
  logic         start, hi_we, lo_we;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           acceptCycle;
    string        name;
  } expect_t;

  expect_t      sbQ[$];
  int           errors = 0;
  int           checks = 0;
  int           cycleCnt = 0;
  int           doneSeen = 0;
  logic [W-1:0] modelHi = '0, modelLo = '0, prevHi = '0, prevLo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .A(A), .B(B), .op(op), .start(start),
    .hi_we(hi_we), .lo_we(lo_we), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  // Cycle counter used to measure accept-to-done latency.
  always @(posedge clk) cycleCnt++;

  // Global time limit so the run always ends.
  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model straight from the arithmetic definition of each op.
  function automatic logic [63:0] refModel(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint       sa, sb, q, r;
    logic [63:0]  p, res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    res = '0;
    case (o)
      2'b00: begin q = sa * sb; res = q; end
      2'b01: begin p = 64'(a) * 64'(b); res = p; end
      default: begin
        if (b == '0) res = {a, 32'hFFFF_FFFF};
        else if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          p = 64'(a) / 64'(b);
          res[31:0] = p[31:0];
          p = 64'(a) % 64'(b);
          res[63:32] = p[31:0];
        end
      end
    endcase
    return res;
  endfunction

  // Monitor: whenever done is presented, pop the oldest expectation and compare.
  initial begin
    expect_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) begin
        doneSeen++;
        if (sbQ.size() == 0) begin
          checkOutput("unexpected_done", 64'(done), 64'(0));
        end else begin
          e = sbQ.pop_front();
          checkOutput({e.name, "_hi"}, 64'(hi), 64'(e.hi));
          checkOutput({e.name, "_lo"}, 64'(lo), 64'(e.lo));
          checkOutput({e.name, "_latency"}, 64'(cycleCnt - e.acceptCycle), 64'(W + 1));
        end
      end
    end
  end

  // Wait for the unit to be idle, then issue one op and log its expected result.
  task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic withLoWe, input string name);
    logic [63:0] r;
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    checkOutput({name, "_idle_before_start"}, 64'(busy), 64'(0));
    op = o; A = a; B = b; start = 1'b1; lo_we = withLoWe;
    r = refModel(o, a, b);
    prevHi = modelHi;
    prevLo = modelLo;
    modelHi = r[63:32];
    modelLo = r[31:0];
    sbQ.push_back('{r[63:32], r[31:0], cycleCnt + 1, name});
    @(negedge clk);
    start = 1'b0; lo_we = 1'b0;
    A = $urandom; B = $urandom; op = 2'($urandom_range(0, 3));
  endtask

  task automatic waitDrain(input string name);
    int t;
    t = 0;
    while ((busy || sbQ.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    checkOutput({name, "_drained"}, 64'(sbQ.size()), 64'(0));
  endtask

  initial begin
    int cnt, d0, sel;
    logic [1:0] o;
    logic [W-1:0] a, b;
    rst_n = 1'b0; A = '0; B = '0; op = '0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 64'(busy), 64'(0));
    checkOutput("reset_done", 64'(done), 64'(0));
    checkOutput("reset_hi", 64'(hi), 64'(0));
    checkOutput("reset_lo", 64'(lo), 64'(0));
    rst_n = 1'b1;

    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_max");
    applyStimulus(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0, "mult_neg3x7");
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    checkOutput("mult_busy_cycles", 64'(cnt), 64'(W + 1));
    applyStimulus(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, "div_neg7by2");
    applyStimulus(2'b11, 32'd100, 32'd7, 1'b0, "divu_100by7");
    applyStimulus(2'b11, 32'h1234, 32'd0, 1'b0, "divu_by0");
    applyStimulus(2'b10, 32'hFFFF_8000, 32'd0, 1'b0, "div_neg_by0");
    applyStimulus(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_overflow");
    waitDrain("directed");

    // Busy: a second start and an MTHI must both be ignored.
    applyStimulus(2'b01, 32'd12345, 32'd678, 1'b0, "multu_busy");
    repeat (3) @(negedge clk);
    start = 1'b1; hi_we = 1'b1; A = 32'hDEAD_BEEF; B = 32'd3; op = 2'b11;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    checkOutput("busy_hi_held", 64'(hi), 64'(prevHi));
    checkOutput("busy_lo_held", 64'(lo), 64'(prevLo));
    waitDrain("busy_ignore");
    checkOutput("busy_result_hi_kept", 64'(hi), 64'(modelHi));

    // Reset mid-CALC: clear immediately and never signal done.
    applyStimulus(2'b10, 32'h7654_3210, 32'd9, 1'b0, "div_aborted");
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", 64'(busy), 64'(0));
    checkOutput("abort_hi", 64'(hi), 64'(0));
    checkOutput("abort_lo", 64'(lo), 64'(0));
    sbQ.delete();
    modelHi = '0; modelLo = '0;
    d0 = doneSeen;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (45) @(negedge clk);
    checkOutput("abort_no_done", 64'(doneSeen), 64'(d0));

    // Idle MTHI, then start with a simultaneous MTLO that must be dropped.
    hi_we = 1'b1; A = 32'hDEAD_BEEF;
    @(negedge clk);
    hi_we = 1'b0;
    checkOutput("mthi_idle", 64'(hi), 64'(32'hDEAD_BEEF));
    modelHi = 32'hDEAD_BEEF;
    applyStimulus(2'b00, 32'h0000_0005, 32'hFFFF_FFFE, 1'b1, "mult_with_lowe");
    @(negedge clk);
    checkOutput("lowe_dropped_lo", 64'(lo), 64'(prevLo));
    checkOutput("lowe_hi_held", 64'(hi), 64'(prevHi));
    waitDrain("lowe");

    // Randomized ops, back to back, biased toward the corner cases.
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = '0;
      else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (sel == 2) b = 32'($urandom_range(1, 15));
      else if (sel == 3) b = -32'($urandom_range(1, 15));
      applyStimulus(o, a, b, 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
    end
    waitDrain("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
